// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one Booth_mul between NREQ requesters.
// Sequences the multiplier enable (LOAD/RUN/CAPTURE/GAP) and aborts runs that exceed TIMEOUT.
module booth_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       a_in,
  input  logic [NREQ*W-1:0]       b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*W-1:0]          rsp_prod,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_en,
  output logic [W-1:0]            mul_a,
  output logic [W-1:0]            mul_b,
  input  logic [2*W-1:0]          mul_prod,
  input  logic                    mul_done
);

  localparam int unsigned IdW    = $clog2(NREQ);
  localparam int unsigned CntMax = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapture, StGap} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    cur_id_q, cur_id_d;
  logic [IdW-1:0]    rsp_id_q, rsp_id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]    rsp_prod_q, rsp_prod_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mul_en_q, mul_en_d;
  logic [W-1:0]      mul_a_q, mul_a_d;
  logic [W-1:0]      mul_b_q, mul_b_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;

  logic              pick_found;
  logic [IdW-1:0]    pick_idx;
  logic [IdW-1:0]    cand;
  logic [W-1:0]      sel_a, sel_b;

  // First set request searching upward from the pointer, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = IdW'((int'(ptr_q) + k) % int'(NREQ));
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx == IdW'(i)) begin
        sel_a = a_in[i*W +: W];
        sel_b = b_in[i*W +: W];
      end
    end
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    rsp_id_d    = rsp_id_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;
    mul_en_d    = mul_en_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d         = StLoad;
          gnt_d[pick_idx] = 1'b1;
          cur_id_d        = pick_idx;
          ptr_d           = (pick_idx == IdW'(NREQ - 1)) ? '0 : pick_idx + IdW'(1);
          mul_a_d         = sel_a;
          mul_b_d         = sel_b;
        end
      end
      StLoad: begin
        state_d  = StRun;
        mul_en_d = 1'b1;
        cnt_d    = '0;
      end
      StRun: begin
        cnt_d = cnt_inc;
        // A done still high on the first RUN cycle is left over from the previous op.
        if (mul_done && cnt_q != '0) begin
          state_d     = StCapture;
          mul_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_prod_d  = mul_prod;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          state_d     = StCapture;
          mul_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      StCapture: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      rsp_id_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      rsp_id_q    <= rsp_id_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural Booth_mul stub of programmable latency.
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              rsp_err;
  logic              busy;
  logic              mul_en;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_prod = '0;
  logic              mul_done = 1'b0;

  booth_mul_arbiter #(
    .NREQ(NREQ), .W(W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .busy(busy), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // Stub multiplier: done rises after stub_lat enabled cycles, clears when en drops.
  int stub_lat   = 3;
  bit stub_never = 1'b0;
  int en_cnt     = 0;
  always @(posedge clk) begin
    if (!mul_en) begin
      en_cnt   <= 0;
      mul_done <= 1'b0;
    end else begin
      en_cnt <= en_cnt + 1;
      if (!stub_never && en_cnt + 1 == stub_lat) begin
        mul_done <= 1'b1;
        mul_prod <= {16'h0, mul_a} * {16'h0, mul_b};
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_rise_cyc = 0, low_run = 0, low_before_en = 0, rsp_count = 0;
  bit en_prev = 1'b0;
  always @(negedge clk) begin
    if (mul_en && !en_prev) begin
      en_rise_cyc   = cyc;
      low_before_en = low_run;
    end
    low_run = mul_en ? 0 : low_run + 1;
    en_prev = mul_en;
    if (rsp_valid) rsp_count++;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, output logic [NREQ-1:0] g, output int gc);
    bit seen = 1'b0;
    g  = '0;
    gc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        seen = 1'b1;
        g    = gnt;
        gc   = cyc;
      end
    end
    if (!seen) check_eq({tag, "_gnt_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input string tag, output logic [1:0] id, output logic [31:0] prod,
                          output logic err, output int rc);
    bit seen = 1'b0;
    id = '0; prod = '0; err = 1'b0; rc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        id   = rsp_id;
        prod = rsp_prod;
        err  = rsp_err;
        rc   = cyc;
      end
    end
    if (!seen) check_eq({tag, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  logic [NREQ-1:0] g;
  logic [1:0]      id;
  logic [31:0]     prod;
  logic            err;
  int              gc, rc, prev_gc, cnt_before;

  logic [15:0] t2_a [4] = '{16'h00F0, 16'h0001, 16'h0004, 16'h0007};
  logic [15:0] t2_b [4] = '{16'h0040, 16'h0003, 16'h0002, 16'h0007};
  logic [31:0] t2_p [4] = '{32'h3C00, 32'd3, 32'd8, 32'd49};

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_prod", rsp_prod, 0);
    check_eq("rst_mul_en", mul_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mul_a", mul_a, 0);

    // 1: single request
    set_ops(0, 16'h4004, 16'h0002);
    req = 4'b0001;
    wait_gnt("t1", g, gc);
    req = 4'b0000;
    check_eq("t1_gnt", g, 4'b0001);
    check_eq("t1_load_en", mul_en, 0);
    check_eq("t1_load_busy", busy, 1);
    check_eq("t1_mul_a", mul_a, 16'h4004);
    wait_rsp("t1", id, prod, err, rc);
    check_eq("t1_id", id, 0);
    check_eq("t1_prod", prod, 32'h0000_8008);
    check_eq("t1_err", err, 0);
    check_eq("t1_cap_en", mul_en, 0);
    check_eq("t1_lat", rc - en_rise_cyc, 4);
    @(negedge clk);
    check_eq("t1_pulse", rsp_valid, 0);
    check_eq("t1_hold", rsp_prod, 32'h0000_8008);

    // 2: all requesters, rotation 0..3
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, t2_a[i], t2_b[i]);
    req = 4'b1111;
    prev_gc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("t2", g, gc);
      if (k == 3) req = 4'b0000;
      check_eq($sformatf("t2_gnt%0d", k), g, 64'(4'b0001 << k));
      if (k > 0) check_eq($sformatf("t2_spacing%0d", k), gc - prev_gc, 9);
      prev_gc = gc;
      wait_rsp("t2", id, prod, err, rc);
      check_eq($sformatf("t2_id%0d", k), id, k);
      check_eq($sformatf("t2_prod%0d", k), prod, t2_p[k]);
      check_eq($sformatf("t2_gap%0d", k), low_before_en >= GAP_CYC, 1);
    end

    // 3: pointer at 2 after serving requester 1, then 0 beats 1
    set_ops(0, 16'd5, 16'd6);
    set_ops(1, 16'h0100, 16'h0100);
    req = 4'b0010;
    wait_gnt("t3a", g, gc);
    req = 4'b0000;
    check_eq("t3_gnt_first", g, 4'b0010);
    wait_rsp("t3a", id, prod, err, rc);
    req = 4'b0011;
    wait_gnt("t3b", g, gc);
    req = 4'b0010;
    check_eq("t3_gnt_wrap", g, 4'b0001);
    wait_rsp("t3b", id, prod, err, rc);
    check_eq("t3_id0", id, 0);
    check_eq("t3_prod0", prod, 32'h1E);
    wait_gnt("t3c", g, gc);
    req = 4'b0000;
    check_eq("t3_gnt_last", g, 4'b0010);
    wait_rsp("t3c", id, prod, err, rc);
    check_eq("t3_id1", id, 1);
    check_eq("t3_prod1", prod, 32'h0001_0000);

    // 4: multiplier never finishes
    stub_never = 1'b1;
    set_ops(2, 16'd9, 16'd9);
    req = 4'b0100;
    wait_gnt("t4", g, gc);
    req = 4'b0000;
    wait_rsp("t4", id, prod, err, rc);
    check_eq("t4_lat", rc - en_rise_cyc, TIMEOUT);
    check_eq("t4_err", err, 1);
    check_eq("t4_prod", prod, 0);
    check_eq("t4_id", id, 2);
    repeat (3) @(negedge clk);
    check_eq("t4_idle", busy, 0);
    stub_never = 1'b0;
    set_ops(3, 16'd7, 16'd7);
    req = 4'b1000;
    wait_gnt("t4b", g, gc);
    req = 4'b0000;
    wait_rsp("t4b", id, prod, err, rc);
    check_eq("t4b_id", id, 3);
    check_eq("t4b_prod", prod, 32'd49);
    check_eq("t4b_err", err, 0);

    // 5: reset during RUN
    set_ops(0, 16'd3, 16'd3);
    req = 4'b0001;
    wait_gnt("t5", g, gc);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    cnt_before = rsp_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_en", mul_en, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_rsp_valid", rsp_valid, 0);
    repeat (8) @(negedge clk);
    check_eq("t5_no_rsp", rsp_count - cnt_before, 0);
    set_ops(1, 16'h00F0, 16'h0040);
    req = 4'b0010;
    wait_gnt("t5b", g, gc);
    req = 4'b0000;
    check_eq("t5b_gnt", g, 4'b0010);
    wait_rsp("t5b", id, prod, err, rc);
    check_eq("t5b_id", id, 1);
    check_eq("t5b_prod", prod, 32'h3C00);

    // 6: done arrives on the same cycle the timeout would fire
    stub_lat = TIMEOUT - 1;
    set_ops(2, 16'h1234, 16'h0010);
    req = 4'b0100;
    wait_gnt("t6", g, gc);
    req = 4'b0000;
    wait_rsp("t6", id, prod, err, rc);
    check_eq("t6_lat", rc - en_rise_cyc, TIMEOUT);
    check_eq("t6_err", err, 0);
    check_eq("t6_prod", prod, 32'h0001_2340);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
